// File: rtl/vga_frame_receiver.sv
// VGA raster receiver: recovers pixel coordinates from h/v sync, checks line and frame
// timing against the configured mode and emits a valid-qualified pixel stream.
module vga_frame_receiver #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter logic        SYNC_POL  = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        vga_h_sync,
    input  logic        vga_v_sync,
    input  logic [3:0]  vga_red,
    input  logic [3:0]  vga_green,
    input  logic [3:0]  vga_blue,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [11:0] pix_rgb,
    output logic        frame_start,
    output logic        frame_done,
    output logic        locked,
    output logic        timing_err,
    output logic [7:0]  err_count
);

    localparam logic [11:0] H_TOTAL  = 12'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK);
    localparam logic [10:0] V_TOTAL  = 11'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK);
    localparam logic [10:0] H_SYNC_W = 11'(H_SYNC);
    localparam logic [10:0] H_START  = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] H_END    = 11'(H_SYNC + H_BACK + H_VISIBLE);
    localparam logic [9:0]  V_START  = 10'(V_SYNC + V_BACK);
    localparam logic [9:0]  V_END    = 10'(V_SYNC + V_BACK + V_VISIBLE);
    localparam logic [9:0]  X_LAST   = 10'(H_VISIBLE - 1);
    localparam logic [9:0]  Y_LAST   = 10'(V_VISIBLE - 1);

    typedef enum logic [1:0] {ST_SEARCH, ST_ACQUIRE, ST_LOCKED} state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_te;

    logic        r_hact, r_vact, r_hact_prev, r_vact_prev;
    logic [11:0] r_rgb;
    logic [10:0] r_h_cnt;
    logic [9:0]  r_v_cnt;
    logic        r_h_seen;

    logic        r_pix_valid, r_frame_start, r_frame_done, r_locked, r_timing_err;
    logic [9:0]  r_pix_x, r_pix_y;
    logic [11:0] r_pix_rgb;
    logic [7:0]  r_err_count;

    logic        w_h_edge, w_h_deassert, w_v_edge;
    logic [10:0] w_h_cnt;
    logic [9:0]  w_v_cnt;
    logic        w_err, w_vis, w_emit;
    logic [9:0]  w_x, w_y;

    assign w_h_edge     = r_hact & ~r_hact_prev;
    assign w_h_deassert = ~r_hact & r_hact_prev;
    assign w_v_edge     = r_vact & ~r_vact_prev;

    assign w_h_cnt = w_h_edge ? '0 : ((r_h_cnt == '1) ? r_h_cnt : r_h_cnt + 11'd1);
    assign w_v_cnt = w_v_edge ? '0 :
                     ((w_h_edge && r_v_cnt != '1) ? r_v_cnt + 10'd1 : r_v_cnt);

    // Line checks wait for one observed hsync edge so a line cut short by reset is not scored.
    assign w_err = (r_state != ST_SEARCH) & (
                     (w_h_edge & r_h_seen & (({1'b0, r_h_cnt} + 12'd1) != H_TOTAL)) |
                     (w_h_deassert & r_h_seen & (w_h_cnt != H_SYNC_W)) |
                     (w_v_edge & (({1'b0, r_v_cnt} + 11'd1) != V_TOTAL)));

    assign w_vis  = (w_h_cnt >= H_START) && (w_h_cnt < H_END) &&
                    (w_v_cnt >= V_START) && (w_v_cnt < V_END);
    assign w_x    = 10'(w_h_cnt - H_START);
    assign w_y    = w_v_cnt - V_START;
    assign w_emit = w_vis & (r_state == ST_LOCKED) & enable & ~w_err;

    always_comb begin
        w_next = r_state;
        w_te   = 1'b0;
        case (r_state)
            ST_SEARCH:  if (w_v_edge) w_next = ST_ACQUIRE;
            ST_ACQUIRE: begin
                if (w_err)         w_next = ST_SEARCH;
                else if (w_v_edge) w_next = ST_LOCKED;
            end
            ST_LOCKED: begin
                if (w_err) begin
                    w_next = ST_SEARCH;
                    w_te   = 1'b1;
                end
            end
            default:    w_next = ST_SEARCH;
        endcase
        if (!enable) begin
            w_next = ST_SEARCH;
            w_te   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_SEARCH;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hact        <= 1'b0;
            r_vact        <= 1'b0;
            r_hact_prev   <= 1'b0;
            r_vact_prev   <= 1'b0;
            r_rgb         <= '0;
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_h_seen      <= 1'b0;
            r_pix_valid   <= 1'b0;
            r_pix_x       <= '0;
            r_pix_y       <= '0;
            r_pix_rgb     <= '0;
            r_frame_start <= 1'b0;
            r_frame_done  <= 1'b0;
            r_locked      <= 1'b0;
            r_timing_err  <= 1'b0;
            r_err_count   <= '0;
        end else begin
            r_hact        <= (vga_h_sync == SYNC_POL);
            r_vact        <= (vga_v_sync == SYNC_POL);
            r_rgb         <= {vga_red, vga_green, vga_blue};
            r_hact_prev   <= r_hact;
            r_vact_prev   <= r_vact;
            r_h_cnt       <= w_h_cnt;
            r_v_cnt       <= w_v_cnt;
            if (w_h_edge) r_h_seen <= 1'b1;
            r_pix_valid   <= w_emit;
            if (w_emit) begin
                r_pix_x   <= w_x;
                r_pix_y   <= w_y;
                r_pix_rgb <= r_rgb;
            end
            r_frame_start <= w_emit & (w_x == '0) & (w_y == '0);
            r_frame_done  <= w_emit & (w_x == X_LAST) & (w_y == Y_LAST);
            r_locked      <= (w_next == ST_LOCKED);
            r_timing_err  <= w_te;
            if (w_te && r_err_count != '1) r_err_count <= r_err_count + 8'd1;
        end
    end

    assign pix_valid   = r_pix_valid;
    assign pix_x       = r_pix_x;
    assign pix_y       = r_pix_y;
    assign pix_rgb     = r_pix_rgb;
    assign frame_start = r_frame_start;
    assign frame_done  = r_frame_done;
    assign locked      = r_locked;
    assign timing_err  = r_timing_err;
    assign err_count   = r_err_count;

endmodule

// File: tb/tb_vga_frame_receiver.sv
// Bench for vga_frame_receiver: reduced raster mode, one active-low and one active-high
// instance driven from the same generator and scored per frame from a table of scenarios.
module tb_vga_frame_receiver;

    localparam int HV = 20, HF = 2, HS = 4, HB = 3;
    localparam int VV = 6,  VF = 2, VS = 2, VB = 3;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int NV = 19;

    typedef struct {
        int n_lines; int long_line; int short_line; int rst_line; int en_off_line;
        bit lock_rise;
        int pix; int fs; int fd; int te; bit lk; int ec;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, enable, hs_act, vs_act;
    logic [11:0] rgb_in;
    logic        hs_n, vs_n;
    assign hs_n = ~hs_act;
    assign vs_n = ~vs_act;

    logic [1:0]       pv, fs, fd, lk, te;
    logic [1:0][9:0]  px, py;
    logic [1:0][11:0] rgb;
    logic [1:0][7:0]  ec;

    vga_frame_receiver #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_POL(1'b0)
    ) u_dut_lo (
        .clk(clk), .rst(rst), .enable(enable), .vga_h_sync(hs_n), .vga_v_sync(vs_n),
        .vga_red(rgb_in[11:8]), .vga_green(rgb_in[7:4]), .vga_blue(rgb_in[3:0]),
        .pix_valid(pv[0]), .pix_x(px[0]), .pix_y(py[0]), .pix_rgb(rgb[0]),
        .frame_start(fs[0]), .frame_done(fd[0]), .locked(lk[0]),
        .timing_err(te[0]), .err_count(ec[0])
    );

    vga_frame_receiver #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_POL(1'b1)
    ) u_dut_hi (
        .clk(clk), .rst(rst), .enable(enable), .vga_h_sync(hs_act), .vga_v_sync(vs_act),
        .vga_red(rgb_in[11:8]), .vga_green(rgb_in[7:4]), .vga_blue(rgb_in[3:0]),
        .pix_valid(pv[1]), .pix_x(px[1]), .pix_y(py[1]), .pix_rgb(rgb[1]),
        .frame_start(fs[1]), .frame_done(fd[1]), .locked(lk[1]),
        .timing_err(te[1]), .err_count(ec[1])
    );

    int n_pass = 0, n_total = 0;
    int n_pix[2], n_fs[2], n_fd[2], n_te[2], n_bad[2];
    logic [9:0]  last_x[2], last_y[2];
    logic [11:0] last_rgb[2];
    logic        g_vis = 1'b0, s_vis = 1'b0;
    logic [9:0]  g_x = '0, g_y = '0, s_x = '0, s_y = '0;
    vec_t        vecs[NV];

    function automatic logic [11:0] grad(input logic [9:0] x, input logic [9:0] y);
        return {x[3:0], y[3:0], x[7:4]};
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic chk_zero(input string tag);
        for (int d = 0; d < 2; d++)
            chk($sformatf("%s.outs_zero.d%0d", tag, d),
                longint'({pv[d], px[d], py[d], rgb[d], fs[d], fd[d], lk[d], te[d], ec[d]}), 0);
    endtask

    // Outputs after edge k belong to the generator sample taken at edge k-1.
    initial begin
        for (int d = 0; d < 2; d++) begin
            n_pix[d] = 0; n_fs[d] = 0; n_fd[d] = 0; n_te[d] = 0; n_bad[d] = 0;
            last_x[d] = '0; last_y[d] = '0; last_rgb[d] = '0;
        end
        forever begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                if (rst) begin
                    last_x[d] = '0; last_y[d] = '0; last_rgb[d] = '0;
                end else begin
                    if (pv[d]) begin
                        n_pix[d]++;
                        if (!(s_vis && px[d] == s_x && py[d] == s_y && rgb[d] == grad(s_x, s_y)))
                            n_bad[d]++;
                        last_x[d] = px[d]; last_y[d] = py[d]; last_rgb[d] = rgb[d];
                    end else if (px[d] != last_x[d] || py[d] != last_y[d] || rgb[d] != last_rgb[d]) begin
                        n_bad[d]++;
                    end
                    if (fs[d]) begin
                        n_fs[d]++;
                        if (!(pv[d] && s_vis && s_x == 10'd0 && s_y == 10'd0)) n_bad[d]++;
                    end
                    if (fd[d]) begin
                        n_fd[d]++;
                        if (!(pv[d] && s_vis && s_x == 10'(HV - 1) && s_y == 10'(VV - 1))) n_bad[d]++;
                    end
                    if (te[d]) n_te[d]++;
                end
            end
            s_vis = g_vis; s_x = g_x; s_y = g_y;
        end
    end

    task automatic run_frame(input int i);
        vec_t v;
        int   len, hw;
        v = vecs[i];
        for (int d = 0; d < 2; d++) begin
            n_pix[d] = 0; n_fs[d] = 0; n_fd[d] = 0; n_te[d] = 0; n_bad[d] = 0;
        end
        enable = 1'b1;
        for (int l = 0; l < v.n_lines; l++) begin
            len = (l == v.long_line) ? HT + 1 : HT;
            hw  = (l == v.short_line) ? HS - 1 : HS;
            for (int h = 0; h < len; h++) begin
                rst = (l == v.rst_line) && (h >= 10) && (h < 13);
                if (l == v.en_off_line && h == 10) enable = 1'b0;
                hs_act = (h < hw);
                vs_act = (l < VS);
                g_vis  = (h >= HS + HB) && (h < HS + HB + HV) && (l >= VS + VB) && (l < VS + VB + VV);
                g_x    = 10'(h - (HS + HB));
                g_y    = 10'(l - (VS + VB));
                rgb_in = g_vis ? grad(g_x, g_y) : 12'h5A5;
                @(negedge clk);
                for (int d = 0; d < 2; d++) begin
                    if (v.lock_rise && l == 0 && h == 0) chk($sformatf("f%0d.lock_early.d%0d", i, d), lk[d], 0);
                    if (v.lock_rise && l == 0 && h == 1) chk($sformatf("f%0d.lock_rise.d%0d", i, d), lk[d], 1);
                    if (l == v.en_off_line && h == 9)  chk($sformatf("f%0d.pv_before_dis.d%0d", i, d), pv[d], 1);
                    if (l == v.en_off_line && h == 10) begin
                        chk($sformatf("f%0d.pv_after_dis.d%0d", i, d), pv[d], 0);
                        chk($sformatf("f%0d.lock_after_dis.d%0d", i, d), lk[d], 0);
                        chk($sformatf("f%0d.ec_after_dis.d%0d", i, d), ec[d], v.ec);
                    end
                end
                if (l == v.rst_line && h == 12) chk_zero($sformatf("f%0d.midreset", i));
            end
        end
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("f%0d.pix_count.d%0d", i, d), n_pix[d], v.pix);
            chk($sformatf("f%0d.frame_start.d%0d", i, d), n_fs[d], v.fs);
            chk($sformatf("f%0d.frame_done.d%0d", i, d), n_fd[d], v.fd);
            chk($sformatf("f%0d.timing_err.d%0d", i, d), n_te[d], v.te);
            chk($sformatf("f%0d.locked.d%0d", i, d), lk[d], v.lk);
            chk($sformatf("f%0d.err_count.d%0d", i, d), ec[d], v.ec);
            chk($sformatf("f%0d.pixel_errors.d%0d", i, d), n_bad[d], 0);
        end
    endtask

    initial begin
        // n_lines long short rst en_off lock_rise | pix fs fd te lk ec
        vecs[0]  = '{VT,     -1, -1, -1, -1, 1'b0,   0, 0, 0, 0, 1'b0, 0};
        vecs[1]  = '{VT,     -1, -1, -1, -1, 1'b1, 120, 1, 1, 0, 1'b1, 0};
        vecs[2]  = '{VT,     -1, -1, -1, -1, 1'b0, 120, 1, 1, 0, 1'b1, 0};
        vecs[3]  = '{VT,      5, -1, -1, -1, 1'b0,  20, 1, 0, 1, 1'b0, 1};
        vecs[4]  = '{VT,     -1, -1, -1, -1, 1'b0,   0, 0, 0, 0, 1'b0, 1};
        vecs[5]  = '{VT,     -1, -1, -1, -1, 1'b1, 120, 1, 1, 0, 1'b1, 1};
        vecs[6]  = '{VT,     -1, -1,  7, -1, 1'b0,  42, 1, 0, 0, 1'b0, 0};
        vecs[7]  = '{VT,     -1, -1, -1, -1, 1'b0,   0, 0, 0, 0, 1'b0, 0};
        vecs[8]  = '{VT,     -1, -1, -1, -1, 1'b1, 120, 1, 1, 0, 1'b1, 0};
        vecs[9]  = '{VT,     -1,  3, -1, -1, 1'b0,   0, 0, 0, 1, 1'b0, 1};
        vecs[10] = '{VT,     -1, -1, -1, -1, 1'b0,   0, 0, 0, 0, 1'b0, 1};
        vecs[11] = '{VT,     -1, -1, -1, -1, 1'b1, 120, 1, 1, 0, 1'b1, 1};
        vecs[12] = '{VT - 1, -1, -1, -1, -1, 1'b0, 120, 1, 1, 0, 1'b1, 1};
        vecs[13] = '{VT,     -1, -1, -1, -1, 1'b0,   0, 0, 0, 1, 1'b0, 2};
        vecs[14] = '{VT,     -1, -1, -1, -1, 1'b0,   0, 0, 0, 0, 1'b0, 2};
        vecs[15] = '{VT,     -1, -1, -1, -1, 1'b1, 120, 1, 1, 0, 1'b1, 2};
        vecs[16] = '{VT,     -1, -1, -1,  7, 1'b0,  42, 1, 0, 0, 1'b0, 2};
        vecs[17] = '{VT,     -1, -1, -1, -1, 1'b0,   0, 0, 0, 0, 1'b0, 2};
        vecs[18] = '{VT,     -1, -1, -1, -1, 1'b1, 120, 1, 1, 0, 1'b1, 2};

        rst = 1'b1; enable = 1'b1; hs_act = 1'b0; vs_act = 1'b0; rgb_in = '0;
        repeat (4) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        for (int i = 0; i < NV; i++) run_frame(i);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
